// File: rtl/aes128_pkg.sv
// Shared AES-128 types and constants for the block-mode controllers.
package aes128_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic {
    AES_ECB = 1'b0,
    AES_CBC = 1'b1
  } aes_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_OUT   = 2'd3
  } dec_ctrl_state_e;

  localparam int unsigned AES128_NR = 10;

  // ECB decrypts without chaining, so its XOR mask is all zeros.
  function automatic aes_block_t cbc_mask(input aes_mode_e mode, input aes_block_t chain);
    return (mode == AES_CBC) ? chain : '0;
  endfunction

endpackage

// File: rtl/aes128_dec_mode_ctrl.sv
// ECB/CBC decryption sequencer around one external aes128_cipher_core_inv.
// Streams ciphertext in, pulses the core, applies CBC chaining and streams plaintext out.
module aes128_dec_mode_ctrl
  import aes128_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             cfg_mode,
  input  logic             iv_load,
  input  logic [127:0]     iv_in,
  input  logic             key_valid,
  input  logic             in_valid,
  input  logic [127:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [127:0]     out_data,
  input  logic             out_ready,
  output logic             core_start,
  output logic [127:0]     core_cipher_text,
  input  logic             core_ready,
  input  logic [127:0]     core_plain_text,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  dec_ctrl_state_e r_state;
  dec_ctrl_state_e w_state_nxt;
  aes_block_t      r_cin;
  aes_block_t      r_chain;
  aes_block_t      r_out_data;
  aes_mode_e       r_mode;
  logic            r_out_valid;
  logic [CNT_W-1:0] r_blk_cnt;

  logic w_idle;
  logic w_in_hs;
  logic w_out_hs;
  logic w_core_done;

  assign w_idle      = (r_state == ST_IDLE);
  // rst_n gating keeps the combinational outputs at zero while reset is held.
  assign in_ready    = rst_n & w_idle & key_valid;
  assign core_start  = rst_n & (r_state == ST_START) & core_ready;
  assign w_in_hs     = in_valid & in_ready;
  assign w_out_hs    = r_out_valid & out_ready;
  assign w_core_done = (r_state == ST_BUSY) & core_ready;

  assign out_valid        = r_out_valid;
  assign out_data         = r_out_data;
  assign core_cipher_text = r_cin;
  assign busy             = ~w_idle;
  assign blk_cnt          = r_blk_cnt;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_in_hs)     w_state_nxt = ST_START;
      ST_START: if (core_ready)  w_state_nxt = ST_BUSY;
      ST_BUSY:  if (core_ready)  w_state_nxt = ST_OUT;
      ST_OUT:   if (w_out_hs)    w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cin       <= '0;
      r_chain     <= '0;
      r_out_data  <= '0;
      r_mode      <= AES_ECB;
      r_out_valid <= 1'b0;
      r_blk_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;

      // IV written here is seen by a block accepted in the same cycle, since chain is only read in BUSY.
      if (w_idle && iv_load) begin
        r_chain <= iv_in;
      end

      if (w_in_hs) begin
        r_cin  <= in_data;
        r_mode <= aes_mode_e'(cfg_mode);
      end

      if (w_core_done) begin
        r_out_data  <= core_plain_text ^ cbc_mask(r_mode, r_chain);
        r_out_valid <= 1'b1;
        if (r_mode == AES_CBC) begin
          r_chain <= r_cin;
        end
      end

      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_blk_cnt   <= r_blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  a_out_hold: assert property (@(posedge clk_sys) disable iff (!rst_n)
    (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_out_data)));

  a_start_single: assert property (@(posedge clk_sys) disable iff (!rst_n)
    core_start |=> !core_start);

endmodule
